// File: rtl/sudoku_pkg.sv
// Shared constants for the button front end: button indices, vector width
// and the default debounce/repeat timing.
package sudoku_pkg;

   localparam int NUM_BUTTONS = 7;

   // Bit positions in the pressed/pulse vectors: {start,right,left,down,up,b,a}.
   localparam int BTN_A     = 0;
   localparam int BTN_B     = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 3;
   localparam int BTN_LEFT  = 4;
   localparam int BTN_RIGHT = 5;
   localparam int BTN_START = 6;

   localparam int DEF_DEBOUNCE_CYCLES = 2;
   localparam int DEF_REPEAT_DELAY    = 0;
   localparam int DEF_REPEAT_PERIOD   = 1;
   localparam int DEF_CNT_W           = 16;

   typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

   // Only the four cursor directions auto-repeat while held.
   function automatic bit repeat_capable(input int idx);
      return (idx >= BTN_UP) && (idx <= BTN_RIGHT);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter, registered
// press pulse and optional hold-to-repeat.
module button_debounce
   import sudoku_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic pulse_o,
   output logic stable_o
);

   // Repeat is active only for capable channels with a non-zero delay.
   localparam bit REP_ON = REPEAT_EN && (REPEAT_DELAY > 0);
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_TOP  = CNT_W'(REPEAT_DELAY);
   // A period longer than the delay would need a negative reload; clamp so
   // the hold counter can never wrap.
   localparam logic [CNT_W-1:0] REP_LOAD =
      (REPEAT_PERIOD >= REPEAT_DELAY) ? '0 : CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             rise, fall;

   // Next-state: debounce the synchronized level, then derive press/repeat pulses.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      hold_d   = hold_q;
      pulse_d  = 1'b0;

      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      rise = !stable_q && stable_d;
      fall = stable_q && !stable_d;

      if (rise) begin
         pulse_d = 1'b1;
         hold_d  = '0;
      end else if (fall || !REP_ON) begin
         hold_d = '0;
      end else if (stable_q) begin
         // Fire on the cycle the hold count reaches the delay, then reload so
         // the next firing lands one period later.
         if (hold_q + CNT_W'(1) == REP_TOP) begin
            pulse_d = 1'b1;
            hold_d  = REP_LOAD;
         end else begin
            hold_d = hold_q + CNT_W'(1);
         end
      end
   end

   // State registers; reset discards any in-progress debounce or hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         hold_q   <= '0;
         pulse_q  <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         pulse_q  <= pulse_d;
      end
   end

   assign pulse_o  = pulse_q;
   assign stable_o = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// Board-pin front end: seven independent debounced buttons producing clean
// one-cycle press pulses, a debounced level vector and an any-press flag.
module button_conditioner
   import sudoku_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_button,
   input  logic       b_button,
   input  logic       up_button,
   input  logic       down_button,
   input  logic       left_button,
   input  logic       right_button,
   input  logic       start_button,
   output logic       a_pulse,
   output logic       b_pulse,
   output logic       up_pulse,
   output logic       down_pulse,
   output logic       left_pulse,
   output logic       right_pulse,
   output logic       start_pulse,
   output logic [6:0] pressed,
   output logic       any_pulse
);

   btn_vec_t raw_vec;
   btn_vec_t pulse_vec;
   btn_vec_t stable_vec;

   assign raw_vec[BTN_A]     = a_button;
   assign raw_vec[BTN_B]     = b_button;
   assign raw_vec[BTN_UP]    = up_button;
   assign raw_vec[BTN_DOWN]  = down_button;
   assign raw_vec[BTN_LEFT]  = left_button;
   assign raw_vec[BTN_RIGHT] = right_button;
   assign raw_vec[BTN_START] = start_button;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_EN      (repeat_capable(i)),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .CNT_W          (CNT_W)
      ) u_btn (
         .clk     (clk),
         .reset   (reset),
         .raw_i   (raw_vec[i]),
         .pulse_o (pulse_vec[i]),
         .stable_o(stable_vec[i])
      );
   end

   assign a_pulse     = pulse_vec[BTN_A];
   assign b_pulse     = pulse_vec[BTN_B];
   assign up_pulse    = pulse_vec[BTN_UP];
   assign down_pulse  = pulse_vec[BTN_DOWN];
   assign left_pulse  = pulse_vec[BTN_LEFT];
   assign right_pulse = pulse_vec[BTN_RIGHT];
   assign start_pulse = pulse_vec[BTN_START];
   assign pressed     = stable_vec;
   // Pulses are registered, so this OR is glitch-free and one cycle wide.
   assign any_pulse   = |pulse_vec;

endmodule
